ex2mem_skid: RTL
================

// Module: ex2mem_skid
// PURPOSE
//  EX->MEM pipeline register for the rv32i core, directly downstream of the ID/EX register and the ALU.
//  Captures the ALU result, store data and the memory/writeback controls of the instruction leaving EX.
//  Uses a valid/ready handshake with a 2-entry skid buffer, so a data-memory wait (mem_ready_i low)
//  back-pressures EX without a combinational ready path.
//  A flush input squashes in-flight entries when a branch or jump is taken.
// PARAMETERS
//  XLEN         32            datapath width
//  BUBBLE_INST  32'h00000013  inst_o value on bubble/reset (addi x0,x0,0)
// PORTS
//  clk               in   1     clock, rising edge
//  rst_n             in   1     asynchronous active-low reset
//  flush_i           in   1     squash all held entries (taken branch/jump)
//  ex_valid_i        in   1     EX presents a valid instruction
//  ex_ready_o        out  1     register can accept (registered, = skid empty)
//  inst_i            in   32    instruction word
//  pc_wb_i           in   XLEN  pc+4 for jal/jalr writeback
//  alu_result_i      in   XLEN  ALU result / memory address
//  store_data_i      in   XLEN  rs2 data (already forwarded)
//  rd_i              in   5     destination register
//  wr_width_i        in   3     funct3 load/store width
//  reg_w_ctrl_i      in   1     regfile write enable, ACTIVE LOW
//  reg_w_data_sel_i  in   1     0=ALU/pc_wb, 1=memory
//  mem_read_ctrl_i   in   1     load
//  mem_write_ctrl_i  in   1     store
//  mem_valid_o       out  1     head entry valid toward MEM
//  mem_ready_i       in   1     MEM consumes head this cycle
//  *_o (inst_o, pc_wb_o, alu_result_o, store_data_o, rd_o, wr_width_o, reg_w_ctrl_o,
//       reg_w_data_sel_o, mem_read_ctrl_o, mem_write_ctrl_o)  out  as inputs  head entry payload
//  fwd_rd_o          out  5     rd of head if it writes the regfile, else 0 (feeds the forwarding unit)
// BEHAVIOUR
//  - Reset (rst_n=0, async):
//    - mem_valid_o=0, ex_ready_o=1, inst_o=BUBBLE_INST, reg_w_ctrl_o=1.
//    - All other outputs 0; fwd_rd_o=0; state=EMPTY.
//  - Bubble encoding: any non-valid head drives the reset values, so MEM/WB never act on garbage.
//  - accept = ex_valid_i & ex_ready_o; drain = mem_valid_o & mem_ready_i.
//  - FSM states, by entries held:
//    - EMPTY: accept -> MAIN loads input, go BUSY.
//    - BUSY:
//      - accept & drain: MAIN reloads, stay BUSY.
//      - accept & ~drain: SKID loads input, go FULL.
//      - ~accept & drain: go EMPTY.
//    - FULL: ex_ready_o=0; drain -> MAIN<=SKID, go BUSY.
//  - Latency: 1 cycle from accept to mem_valid_o when not stalled. Order strictly preserved.
//  - flush_i=1: next state EMPTY, both slots bubble, ex_ready_o=1 next cycle.
//    flush beats a same-cycle accept; the current head may still drain this cycle.
//  - ex_ready_o is registered from next-state (next != FULL); no input->ready combinational path.
//  - Payload passes bit-exact; no arithmetic. reg_w_ctrl_i/_o stay active-low throughout.
//  - fwd_rd_o = (mem_valid_o & ~reg_w_ctrl_o) ? rd_o : 5'd0; rd=0 is never forwarded.
//  - Reset mid-stall: both entries dropped immediately, no partial writeback.
// STRUCTURE
//  - defines.v: `ZERO_WORD, `NOP_INST, state encodings EX2MEM_EMPTY/BUSY/FULL (2-bit).
//  - Sub-module ex2mem_slot: payload register with load/clear_to_bubble; instantiated twice (MAIN, SKID).
//  - Top holds the FSM, handshake and forwarding mux.
// TESTING
//  1. Reset: rst_n=0 mid-cycle -> outputs clear immediately;
//     mem_valid_o=0, inst_o=32'h13, reg_w_ctrl_o=1, ex_ready_o=1.
//  2. Stream without stall (mem_ready_i=1):
//     3 back-to-back valid instr, alu_result 0x10/0x20/0x30 -> appear on alu_result_o cycles 1,2,3; valid held.
//  3. Stall:
//     accept A, mem_ready_i=0, accept B -> FULL, ex_ready_o=0.
//     Release -> A then B delivered, ex_ready_o=1 one cycle after the first drain.
//  4. Flush in FULL with simultaneous ex_valid_i=1 ->
//     next cycle mem_valid_o=0, fwd_rd_o=0, new input not captured.
//  5. Forwarding:
//     store (reg_w_ctrl_i=1, rd=5) -> fwd_rd_o=0.
//     add rd=5 -> fwd_rd_o=5.
//     add rd=0 -> fwd_rd_o=0.

Source files
------------

// File: rtl/ex2mem_skid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex2mem_skid_pkg
// Description : Shared constants for the EX->MEM skid register: FSM state
//               encodings, payload field widths and the bubble instruction.
// Revision    : 1.0 - initial release
// ============================================================================
package ex2mem_skid_pkg;

   // FSM states, named by the number of entries held
   localparam logic [1:0] EX2MEM_EMPTY = 2'd0;
   localparam logic [1:0] EX2MEM_BUSY  = 2'd1;
   localparam logic [1:0] EX2MEM_FULL  = 2'd2;

   localparam logic [31:0] NOP_INST  = 32'h0000_0013;  // addi x0,x0,0
   localparam int          INST_W    = 32;
   localparam int          RD_W      = 5;
   localparam int          WIDTH_W   = 3;
   localparam int          CTRL_W    = 4;              // reg_w, data_sel, mem_read, mem_write

   // Packed payload width for a given datapath width
   function automatic int payload_w(input int xlen);
      return INST_W + 3 * xlen + RD_W + WIDTH_W + CTRL_W;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ex2mem_slot.sv
`default_nettype none
// ============================================================================
// Module      : ex2mem_slot
// Description : One payload register of the skid buffer. Loads d_i, or is
//               forced back to the bubble pattern (clear wins over load).
// Revision    : 1.0 - initial release
// ============================================================================
module ex2mem_slot
   import ex2mem_skid_pkg::*;
#(
   parameter int            PW     = 8,
   parameter logic [PW-1:0] BUBBLE = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_i,
   input  logic          clear_i,
   input  logic [PW-1:0] d_i,
   output logic [PW-1:0] q_o
);

   logic [PW-1:0] data_q;
   logic [PW-1:0] data_d;

   // Next payload: bubble on clear, new data on load, otherwise hold
   always_comb begin
      data_d = data_q;
      if (clear_i) begin
         data_d = BUBBLE;
      end else if (load_i) begin
         data_d = d_i;
      end
   end

   // Payload storage, bubble on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= BUBBLE;
      end else begin
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule
`default_nettype wire

// File: rtl/ex2mem_skid.sv
`default_nettype none
// ============================================================================
// Module      : ex2mem_skid
// Description : EX->MEM pipeline register with a 2-entry skid buffer. MAIN
//               is always the head presented to MEM; SKID catches the one
//               extra instruction accepted while MEM stalls. Ready is a flop.
// Revision    : 1.0 - initial release
// ============================================================================
module ex2mem_skid
   import ex2mem_skid_pkg::*;
#(
   parameter int          XLEN        = 32,
   parameter logic [31:0] BUBBLE_INST = NOP_INST
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_i,
   input  logic            ex_valid_i,
   output logic            ex_ready_o,
   input  logic [31:0]     inst_i,
   input  logic [XLEN-1:0] pc_wb_i,
   input  logic [XLEN-1:0] alu_result_i,
   input  logic [XLEN-1:0] store_data_i,
   input  logic [4:0]      rd_i,
   input  logic [2:0]      wr_width_i,
   input  logic            reg_w_ctrl_i,
   input  logic            reg_w_data_sel_i,
   input  logic            mem_read_ctrl_i,
   input  logic            mem_write_ctrl_i,
   output logic            mem_valid_o,
   input  logic            mem_ready_i,
   output logic [31:0]     inst_o,
   output logic [XLEN-1:0] pc_wb_o,
   output logic [XLEN-1:0] alu_result_o,
   output logic [XLEN-1:0] store_data_o,
   output logic [4:0]      rd_o,
   output logic [2:0]      wr_width_o,
   output logic            reg_w_ctrl_o,
   output logic            reg_w_data_sel_o,
   output logic            mem_read_ctrl_o,
   output logic            mem_write_ctrl_o,
   output logic [4:0]      fwd_rd_o
);

   localparam int PW = payload_w(XLEN);
   // Bubble: NOP instruction, regfile write disabled (active low = 1), rest 0
   localparam logic [PW-1:0] BUBBLE_PL =
      {BUBBLE_INST, {(3 * XLEN + RD_W + WIDTH_W) {1'b0}}, 1'b1, 3'b000};

   logic [1:0]    state_q, state_d;
   logic          ready_q, ready_d;
   logic          accept, drain;
   logic          main_load, main_from_skid, main_clr;
   logic          skid_load, skid_clr;
   logic [PW-1:0] in_pl, main_d_pl, main_pl, skid_pl;

   assign in_pl = {inst_i, pc_wb_i, alu_result_i, store_data_i, rd_i, wr_width_i,
                   reg_w_ctrl_i, reg_w_data_sel_i, mem_read_ctrl_i, mem_write_ctrl_i};

   assign mem_valid_o = (state_q != EX2MEM_EMPTY);
   assign ex_ready_o  = ready_q;
   assign accept      = ex_valid_i & ready_q;
   assign drain       = mem_valid_o & mem_ready_i;

   // Occupancy FSM and slot steering; flush overrides any accept
   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      main_clr       = 1'b0;
      skid_load      = 1'b0;
      skid_clr       = 1'b0;
      if (flush_i) begin
         state_d  = EX2MEM_EMPTY;
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else begin
         case (state_q)
            EX2MEM_EMPTY: begin
               if (accept) begin
                  main_load = 1'b1;
                  state_d   = EX2MEM_BUSY;
               end
            end
            EX2MEM_BUSY: begin
               if (accept && drain) begin
                  main_load = 1'b1;
               end else if (accept) begin
                  skid_load = 1'b1;
                  state_d   = EX2MEM_FULL;
               end else if (drain) begin
                  main_clr  = 1'b1;
                  state_d   = EX2MEM_EMPTY;
               end
            end
            EX2MEM_FULL: begin
               if (drain) begin
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clr       = 1'b1;
                  state_d        = EX2MEM_BUSY;
               end
            end
            default: begin
               state_d  = EX2MEM_EMPTY;
               main_clr = 1'b1;
               skid_clr = 1'b1;
            end
         endcase
      end
      ready_d = (state_d != EX2MEM_FULL);
   end

   // State and registered ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EX2MEM_EMPTY;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
      end
   end

   assign main_d_pl = main_from_skid ? skid_pl : in_pl;

   ex2mem_slot #(.PW(PW), .BUBBLE(BUBBLE_PL)) u_main (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (main_load),
      .clear_i (main_clr),
      .d_i     (main_d_pl),
      .q_o     (main_pl)
   );

   ex2mem_slot #(.PW(PW), .BUBBLE(BUBBLE_PL)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (skid_load),
      .clear_i (skid_clr),
      .d_i     (in_pl),
      .q_o     (skid_pl)
   );

   // MAIN is always the head; it holds the bubble whenever it is empty
   assign {inst_o, pc_wb_o, alu_result_o, store_data_o, rd_o, wr_width_o,
           reg_w_ctrl_o, reg_w_data_sel_o, mem_read_ctrl_o, mem_write_ctrl_o} = main_pl;

   assign fwd_rd_o = (mem_valid_o && !reg_w_ctrl_o) ? rd_o : 5'd0;

endmodule
`default_nettype wire
